// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - four-source round-robin common data bus arbiter with per-source holding slots
module cdb_arbiter #(
    parameter int ROB_DEPTH = 64,
    parameter int PREG_W    = 6,
    localparam int IW       = $clog2(ROB_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [3:0]             req_valid,
    output logic [3:0]             req_ready,
    input  logic [3:0][IW-1:0]     req_rob_idx,
    input  logic [3:0][PREG_W-1:0] req_pd,
    input  logic [3:0][31:0]       req_wdata,
    output logic                   cdb_valid,
    output logic [1:0]             cdb_src,
    output logic [IW-1:0]          cdb_rob_idx,
    output logic [PREG_W-1:0]      cdb_pd,
    output logic [31:0]            cdb_wdata
);

    // One holding slot per execution unit
    logic [3:0]             slot_valid;
    logic [3:0][IW-1:0]     slot_rob_idx;
    logic [3:0][PREG_W-1:0] slot_pd;
    logic [3:0][31:0]       slot_wdata;

    logic [1:0] rr_ptr;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic [1:0] probe;
    logic [3:0] xfer;

    // Round-robin pick over occupied slots only; squashed entirely during reset or flush
    always_comb begin
        grant   = '0;
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        probe   = rr_ptr;
        if (!rst && !flush) begin
            for (int k = 0; k < 4; k++) begin
                probe = rr_ptr + 2'(k);
                if (!gnt_any && slot_valid[probe]) begin
                    grant[probe] = 1'b1;
                    gnt_idx      = probe;
                    gnt_any      = 1'b1;
                end
            end
        end
    end

    // A slot accepts when empty or when it is being drained this cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < 4; i++) begin
            req_ready[i] = !rst && !flush && (!slot_valid[i] || grant[i]);
        end
        xfer = req_valid & req_ready;
    end

    // Slot fill/drain, broadcast register and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid   <= '0;
            slot_rob_idx <= '0;
            slot_pd      <= '0;
            slot_wdata   <= '0;
            rr_ptr       <= '0;
            cdb_valid    <= 1'b0;
            cdb_src      <= '0;
            cdb_rob_idx  <= '0;
            cdb_pd       <= '0;
            cdb_wdata    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (xfer[i]) begin
                    slot_valid[i]   <= 1'b1;
                    slot_rob_idx[i] <= req_rob_idx[i];
                    slot_pd[i]      <= req_pd[i];
                    slot_wdata[i]   <= req_wdata[i];
                end else if (grant[i] || flush) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            if (gnt_any) begin
                cdb_valid   <= 1'b1;
                cdb_src     <= gnt_idx;
                cdb_rob_idx <= slot_rob_idx[gnt_idx];
                cdb_pd      <= slot_pd[gnt_idx];
                cdb_wdata   <= slot_wdata[gnt_idx];
                rr_ptr      <= gnt_idx + 2'd1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
